// File: rtl/riscv_v_uop_sequencer.sv
// Vector micro-op sequencer: expands one decoded vector instruction into per-register
// uops across its LMUL group, with per-byte active masks derived from vl/vstart.
module riscv_v_uop_sequencer #(
  parameter int RF_ADDR_WIDTH = 5,
  parameter int NUM_BYTES     = 16,
  parameter int MAX_LMUL      = 8,
  parameter int VL_WIDTH      = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_pipe,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [RF_ADDR_WIDTH-1:0] req_vd,
  input  logic [RF_ADDR_WIDTH-1:0] req_vs1,
  input  logic [RF_ADDR_WIDTH-1:0] req_vs2,
  input  logic                     req_srca_scalar,
  input  logic [2:0]               req_vlmul,
  input  logic [2:0]               req_vsew,
  input  logic [VL_WIDTH-1:0]      req_vl,
  input  logic [VL_WIDTH-1:0]      req_vstart,
  output logic                     uop_valid,
  input  logic                     uop_ready,
  output logic [RF_ADDR_WIDTH-1:0] uop_vd,
  output logic [RF_ADDR_WIDTH-1:0] uop_vs1,
  output logic [RF_ADDR_WIDTH-1:0] uop_vs2,
  output logic [NUM_BYTES-1:0]     uop_byte_en,
  output logic                     uop_last,
  output logic                     busy,
  output logic                     done,
  output logic                     err_misaligned
);

  localparam int SH    = $clog2(NUM_BYTES);
  localparam int IDX_W = $clog2(MAX_LMUL);
  localparam int VW    = VL_WIDTH + 1;

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_e;

  state_e                   state_q, state_d;
  logic [RF_ADDR_WIDTH-1:0] vd_q, vd_d, vs1_q, vs1_d, vs2_q, vs2_d;
  logic                     scalar_q, scalar_d;
  logic [1:0]               sew_q, sew_d;
  logic [VL_WIDTH-1:0]      vl_q, vl_d, vstart_q, vstart_d;
  logic [IDX_W-1:0]         idx_q, idx_d, last_q, last_d;
  logic                     done_q, done_d, err_q, err_d;

  logic [7:0]               sh_s, sh_q_s;
  logic [VW-1:0]            grp_s, epr_m1_s, ceil_s, first_s, n_s, e_s;
  logic [RF_ADDR_WIDTH-1:0] mask_s;
  logic                     mis_s, empty_s;
  logic [NUM_BYTES-1:0]     byte_en_s;
  logic                     unused_s;

  assign unused_s = req_vsew[2];

  // Request-side decode: group size, register count, alignment and empty checks
  always_comb begin
    sh_s     = 8'(SH) - {6'd0, req_vsew[1:0]};
    grp_s    = req_vlmul[2] ? VW'(1) : (VW'(1) << req_vlmul[1:0]);
    epr_m1_s = (VW'(1) << sh_s) - VW'(1);
    ceil_s   = (VW'(req_vl) + epr_m1_s) >> sh_s;
    first_s  = VW'(req_vstart) >> sh_s;
    n_s      = (ceil_s < grp_s) ? ceil_s : grp_s;
    mask_s   = RF_ADDR_WIDTH'(grp_s) - RF_ADDR_WIDTH'(1);
    mis_s    = (|(req_vd & mask_s)) || (|(req_vs2 & mask_s)) ||
               (!req_srca_scalar && (|(req_vs1 & mask_s)));
    empty_s  = (req_vl == '0) || (req_vstart >= req_vl) || (first_s >= n_s);
  end

  // Byte mask of the current uop: element index e = idx*EPR + (b >> sew)
  always_comb begin
    sh_q_s    = 8'(SH) - {6'd0, sew_q};
    byte_en_s = '0;
    e_s       = '0;
    for (int b = 0; b < NUM_BYTES; b++) begin
      e_s          = (VW'(idx_q) << sh_q_s) + (VW'(b) >> sew_q);
      byte_en_s[b] = (e_s >= VW'(vstart_q)) && (e_s < VW'(vl_q));
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    vd_d     = vd_q;
    vs1_d    = vs1_q;
    vs2_d    = vs2_q;
    scalar_d = scalar_q;
    sew_d    = sew_q;
    vl_d     = vl_q;
    vstart_d = vstart_q;
    idx_d    = idx_q;
    last_d   = last_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid && !clear_pipe) begin
          vd_d     = req_vd;
          vs1_d    = req_vs1;
          vs2_d    = req_vs2;
          scalar_d = req_srca_scalar;
          sew_d    = req_vsew[1:0];
          vl_d     = req_vl;
          vstart_d = req_vstart;
          if (mis_s) begin
            err_d = 1'b1;
          end else if (empty_s) begin
            done_d = 1'b1;
          end else begin
            state_d = ISSUE;
            idx_d   = first_s[IDX_W-1:0];
            last_d  = IDX_W'(n_s - VW'(1));
          end
        end
      end
      ISSUE: begin
        if (clear_pipe) begin
          state_d = IDLE;
        end else if (uop_ready) begin
          if (idx_q == last_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      vd_q     <= '0;
      vs1_q    <= '0;
      vs2_q    <= '0;
      scalar_q <= 1'b0;
      sew_q    <= 2'd0;
      vl_q     <= '0;
      vstart_q <= '0;
      idx_q    <= '0;
      last_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      vd_q     <= vd_d;
      vs1_q    <= vs1_d;
      vs2_q    <= vs2_d;
      scalar_q <= scalar_d;
      sew_q    <= sew_d;
      vl_q     <= vl_d;
      vstart_q <= vstart_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // uop fields are gated so every output reads 0 outside ISSUE
  assign uop_valid      = (state_q == ISSUE);
  assign busy           = uop_valid;
  assign req_ready      = (state_q == IDLE) && !clear_pipe;
  assign uop_vd         = uop_valid ? vd_q + RF_ADDR_WIDTH'(idx_q) : '0;
  assign uop_vs2        = uop_valid ? vs2_q + RF_ADDR_WIDTH'(idx_q) : '0;
  assign uop_vs1        = !uop_valid ? '0 : (scalar_q ? vs1_q : vs1_q + RF_ADDR_WIDTH'(idx_q));
  assign uop_byte_en    = uop_valid ? byte_en_s : '0;
  assign uop_last       = uop_valid && (idx_q == last_q);
  assign done           = done_q;
  assign err_misaligned = err_q;

endmodule

// File: tb/tb_riscv_v_uop_sequencer.sv
// Directed self-checking bench for riscv_v_uop_sequencer.
module tb_riscv_v_uop_sequencer;

  logic        clk, rst, clear_pipe, req_valid, req_ready, req_srca_scalar;
  logic [4:0]  req_vd, req_vs1, req_vs2, uop_vd, uop_vs1, uop_vs2;
  logic [2:0]  req_vlmul, req_vsew;
  logic [7:0]  req_vl, req_vstart;
  logic        uop_valid, uop_ready, uop_last, busy, done, err_misaligned;
  logic [15:0] uop_byte_en;
  int          tests, fails;

  riscv_v_uop_sequencer dut (
    .clk(clk), .rst(rst), .clear_pipe(clear_pipe),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_vd(req_vd), .req_vs1(req_vs1), .req_vs2(req_vs2),
    .req_srca_scalar(req_srca_scalar), .req_vlmul(req_vlmul), .req_vsew(req_vsew),
    .req_vl(req_vl), .req_vstart(req_vstart),
    .uop_valid(uop_valid), .uop_ready(uop_ready),
    .uop_vd(uop_vd), .uop_vs1(uop_vs1), .uop_vs2(uop_vs2),
    .uop_byte_en(uop_byte_en), .uop_last(uop_last),
    .busy(busy), .done(done), .err_misaligned(err_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [4:0] vd, input logic [4:0] vs1, input logic [4:0] vs2,
                      input logic sc, input logic [2:0] lmul, input logic [2:0] sew,
                      input logic [7:0] vl, input logic [7:0] vst);
    req_vd = vd; req_vs1 = vs1; req_vs2 = vs2; req_srca_scalar = sc;
    req_vlmul = lmul; req_vsew = sew; req_vl = vl; req_vstart = vst;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    tests = 0; fails = 0;
    rst = 1'b0; clear_pipe = 1'b0; req_valid = 1'b0; uop_ready = 1'b1;
    req_vd = '0; req_vs1 = '0; req_vs2 = '0; req_srca_scalar = 1'b0;
    req_vlmul = '0; req_vsew = '0; req_vl = '0; req_vstart = '0;
    #2;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_uop_valid", uop_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_misaligned, 0);
    chk("rst_byte_en", uop_byte_en, 0);
    rst = 1'b1;
    step();

    // 1: single uop, LMUL=1
    send(5'd2, 5'd0, 5'd0, 1'b0, 3'd0, 3'd0, 8'd16, 8'd0);
    chk("t1_valid", uop_valid, 1);
    chk("t1_vd", uop_vd, 2);
    chk("t1_be", uop_byte_en, 16'hFFFF);
    chk("t1_last", uop_last, 1);
    chk("t1_ready", req_ready, 0);
    step();
    chk("t1_done", done, 1);
    chk("t1_valid_off", uop_valid, 0);
    chk("t1_req_ready", req_ready, 1);
    step();
    chk("t1_done_pulse", done, 0);

    // 2: LMUL=4, SEW=32, vl=10 -> 3 uops
    send(5'd8, 5'd12, 5'd4, 1'b0, 3'd2, 3'd2, 8'd10, 8'd0);
    for (int i = 0; i < 3; i++) begin
      chk("t2_valid", uop_valid, 1);
      chk("t2_vd", uop_vd, 8 + i);
      chk("t2_vs1", uop_vs1, 12 + i);
      chk("t2_vs2", uop_vs2, 4 + i);
      chk("t2_be", uop_byte_en, (i == 2) ? 16'h00FF : 16'hFFFF);
      chk("t2_last", uop_last, (i == 2) ? 1 : 0);
      step();
    end
    chk("t2_done", done, 1);
    chk("t2_valid_off", uop_valid, 0);
    // back-to-back accept during the done cycle: empty request
    send(5'd0, 5'd0, 5'd0, 1'b0, 3'd0, 3'd0, 8'd0, 8'd0);
    chk("t2_b2b_done", done, 1);
    step();

    // 3: misaligned vd for LMUL=2
    send(5'd3, 5'd0, 5'd0, 1'b0, 3'd1, 3'd0, 8'd32, 8'd0);
    chk("t3_err", err_misaligned, 1);
    chk("t3_valid", uop_valid, 0);
    chk("t3_done", done, 0);
    chk("t3_ready", req_ready, 1);
    step();
    chk("t3_err_pulse", err_misaligned, 0);
    chk("t3_valid2", uop_valid, 0);

    // 4: LMUL=8, stall on uop 2
    send(5'd16, 5'd24, 5'd8, 1'b0, 3'd3, 3'd0, 8'd128, 8'd0);
    step();
    step();
    uop_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("t4_hold_vd", uop_vd, 18);
      chk("t4_hold_vs1", uop_vs1, 26);
      chk("t4_hold_be", uop_byte_en, 16'hFFFF);
      chk("t4_hold_valid", uop_valid, 1);
      chk("t4_hold_busy", busy, 1);
      step();
    end
    uop_ready = 1'b1;
    for (int i = 2; i < 8; i++) begin
      chk("t4_vd", uop_vd, 16 + i);
      chk("t4_busy", busy, 1);
      chk("t4_last", uop_last, (i == 7) ? 1 : 0);
      step();
    end
    chk("t4_done", done, 1);
    chk("t4_busy_off", busy, 0);
    step();

    // 5: clear_pipe during uop 2, then clear with same-cycle request
    send(5'd0, 5'd5, 5'd0, 1'b1, 3'd3, 3'd0, 8'd128, 8'd0);
    chk("t5_scalar_vs1", uop_vs1, 5);
    step();
    step();
    chk("t5_vd2", uop_vd, 2);
    clear_pipe = 1'b1;
    #1;
    chk("t5_ready_clr", req_ready, 0);
    step();
    clear_pipe = 1'b0;
    chk("t5_valid", uop_valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    clear_pipe = 1'b1;
    send(5'd2, 5'd0, 5'd0, 1'b0, 3'd0, 3'd0, 8'd16, 8'd0);
    clear_pipe = 1'b0;
    chk("t5_noacc_valid", uop_valid, 0);
    chk("t5_noacc_done", done, 0);
    send(5'd2, 5'd0, 5'd0, 1'b0, 3'd0, 3'd0, 8'd16, 8'd0);
    chk("t5_new_valid", uop_valid, 1);
    chk("t5_new_vd", uop_vd, 2);
    step();
    chk("t5_new_done", done, 1);
    step();

    // 6: empty, vstart mask, reset mid-sequence
    send(5'd0, 5'd0, 5'd0, 1'b0, 3'd0, 3'd0, 8'd0, 8'd0);
    chk("t6_empty_done", done, 1);
    chk("t6_empty_valid", uop_valid, 0);
    step();
    send(5'd4, 5'd0, 5'd0, 1'b0, 3'd0, 3'd0, 8'd16, 8'd5);
    chk("t6_vstart_be", uop_byte_en, 16'hFFE0);
    chk("t6_vstart_last", uop_last, 1);
    step();
    chk("t6_vstart_done", done, 1);
    step();
    send(5'd8, 5'd8, 5'd8, 1'b0, 3'd3, 3'd0, 8'd128, 8'd0);
    step();
    chk("t6_pre_vd", uop_vd, 9);
    rst = 1'b0;
    #1;
    chk("t6_rst_valid", uop_valid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_vd", uop_vd, 0);
    chk("t6_rst_ready", req_ready, 1);
    rst = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
